// File: rtl/addr_gen_wu_2d_if.sv
// Control, configuration and status bundle for the 2-D weight-update address generator.
interface addr_gen_wu_2d_if #(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned DIM_WIDTH   = 8,
   parameter int unsigned PAUSE_WIDTH = 4
);
   logic                   en;
   logic                   i_start;
   logic [ADDR_WIDTH-1:0]  i_base;
   logic [DIM_WIDTH-1:0]   i_row_len;
   logic [DIM_WIDTH-1:0]   i_num_rows;
   logic [PAUSE_WIDTH-1:0] i_pause;
   logic                   i_transpose;
   logic [ADDR_WIDTH-1:0]  o_addr;
   logic                   o_valid;
   logic                   o_row_end;
   logic                   o_last;
   logic                   o_busy;
   logic                   o_done;

   modport master (
      output en, i_start, i_base, i_row_len, i_num_rows, i_pause, i_transpose,
      input  o_addr, o_valid, o_row_end, o_last, o_busy, o_done
   );

   modport slave (
      input  en, i_start, i_base, i_row_len, i_num_rows, i_pause, i_transpose,
      output o_addr, o_valid, o_row_end, o_last, o_busy, o_done
   );
endinterface

// File: rtl/addr_gen_wu_2d.sv
// Row-major / transposed 2-D address walker with optional inter-row bubble and
// start/busy/done handshake. Row starts come from an accumulator, so no multiplier.
module addr_gen_wu_2d #(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned DIM_WIDTH   = 8,
   parameter int unsigned PAUSE_WIDTH = 4
) (
   input logic             clk,
   input logic             rst,
   addr_gen_wu_2d_if.slave bus
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StPause = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]  row_start_q, row_start_d;
   logic [DIM_WIDTH-1:0]   i_q, i_d, j_q, j_d;
   logic [DIM_WIDTH-1:0]   c_q, c_d, r_q, r_d;
   logic [PAUSE_WIDTH-1:0] pause_q, pause_d, pause_cnt_q, pause_cnt_d;
   logic                   transpose_q, transpose_d;

   logic                   run;
   logic                   row_end;
   logic                   last_row;
   logic [ADDR_WIDTH-1:0]  stride;
   logic [ADDR_WIDTH-1:0]  next_row_start;

   assign run            = (state_q == StRun);
   assign row_end        = (j_q == c_q - DIM_WIDTH'(1));
   assign last_row       = (i_q == r_q - DIM_WIDTH'(1));
   assign stride         = transpose_q ? ADDR_WIDTH'(r_q) : ADDR_WIDTH'(1);
   assign next_row_start = row_start_q + (transpose_q ? ADDR_WIDTH'(1) : ADDR_WIDTH'(c_q));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      row_start_d = row_start_q;
      i_d         = i_q;
      j_d         = j_q;
      c_d         = c_q;
      r_d         = r_q;
      pause_d     = pause_q;
      pause_cnt_d = pause_cnt_q;
      transpose_d = transpose_q;
      case (state_q)
         StIdle: begin
            // Start is accepted regardless of en.
            if (bus.i_start) begin
               c_d         = bus.i_row_len;
               r_d         = bus.i_num_rows;
               pause_d     = bus.i_pause;
               transpose_d = bus.i_transpose;
               i_d         = '0;
               j_d         = '0;
               if (bus.i_row_len == '0 || bus.i_num_rows == '0) begin
                  state_d = StDone;
               end else begin
                  state_d     = StRun;
                  addr_d      = bus.i_base;
                  row_start_d = bus.i_base;
               end
            end
         end
         StRun: begin
            if (bus.en) begin
               if (!row_end) begin
                  j_d    = j_q + DIM_WIDTH'(1);
                  addr_d = addr_q + stride;
               end else if (last_row) begin
                  state_d = StDone;
               end else if (pause_q != '0) begin
                  state_d     = StPause;
                  pause_cnt_d = pause_q;
               end else begin
                  i_d         = i_q + DIM_WIDTH'(1);
                  j_d         = '0;
                  addr_d      = next_row_start;
                  row_start_d = next_row_start;
               end
            end
         end
         StPause: begin
            if (bus.en) begin
               if (pause_cnt_q == PAUSE_WIDTH'(1)) begin
                  state_d     = StRun;
                  i_d         = i_q + DIM_WIDTH'(1);
                  j_d         = '0;
                  addr_d      = next_row_start;
                  row_start_d = next_row_start;
               end else begin
                  pause_cnt_d = pause_cnt_q - PAUSE_WIDTH'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         row_start_q <= '0;
         i_q         <= '0;
         j_q         <= '0;
         c_q         <= '0;
         r_q         <= '0;
         pause_q     <= '0;
         pause_cnt_q <= '0;
         transpose_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         row_start_q <= row_start_d;
         i_q         <= i_d;
         j_q         <= j_d;
         c_q         <= c_d;
         r_q         <= r_d;
         pause_q     <= pause_d;
         pause_cnt_q <= pause_cnt_d;
         transpose_q <= transpose_d;
      end
   end

   assign bus.o_addr    = addr_q;
   assign bus.o_valid   = run;
   assign bus.o_row_end = run && row_end;
   assign bus.o_last    = run && row_end && last_row;
   assign bus.o_busy    = run || (state_q == StPause);
   assign bus.o_done    = (state_q == StDone);

endmodule

// File: tb/tb_addr_gen_wu_2d.sv
// Directed bench for addr_gen_wu_2d: fixed walks with hand-computed address/flag traces.
module tb_addr_gen_wu_2d;

   // Flag vectors: {valid, row_end, last, busy, done}
   localparam logic [4:0] FRun  = 5'b10010;
   localparam logic [4:0] FRe   = 5'b11010;
   localparam logic [4:0] FLast = 5'b11110;
   localparam logic [4:0] FPau  = 5'b00010;
   localparam logic [4:0] FDone = 5'b00001;
   localparam logic [4:0] FIdle = 5'b00000;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   addr_gen_wu_2d_if #(.ADDR_WIDTH(12), .DIM_WIDTH(8), .PAUSE_WIDTH(4)) bus ();
   addr_gen_wu_2d_if #(.ADDR_WIDTH(4), .DIM_WIDTH(8), .PAUSE_WIDTH(4)) bus4 ();

   addr_gen_wu_2d #(.ADDR_WIDTH(12), .DIM_WIDTH(8), .PAUSE_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   addr_gen_wu_2d #(.ADDR_WIDTH(4), .DIM_WIDTH(8), .PAUSE_WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] flags();
      return {bus.o_valid, bus.o_row_end, bus.o_last, bus.o_busy, bus.o_done};
   endfunction

   // Check flags and address at the current cycle, then advance one clock.
   task automatic exp_run(input string tag, input logic [4:0] fl, input int addr);
      check(tag, {15'd0, flags(), bus.o_addr}, {15'd0, fl, 12'(addr)});
      tick();
   endtask

   task automatic exp_fl(input string tag, input logic [4:0] fl);
      check(tag, {27'd0, flags()}, {27'd0, fl});
      tick();
   endtask

   task automatic start(input int base, input int c, input int r, input int p, input logic t);
      bus.i_base      = 12'(base);
      bus.i_row_len   = 8'(c);
      bus.i_num_rows  = 8'(r);
      bus.i_pause     = 4'(p);
      bus.i_transpose = t;
      bus.i_start     = 1'b1;
      tick();
      bus.i_start     = 1'b0;
   endtask

   initial begin
      int a5[4];
      logic [4:0] f5[4];
      n_pass  = 0;
      n_total = 0;
      rst = 1'b1;
      bus.en = 1'b1; bus.i_start = 1'b0; bus.i_base = '0; bus.i_row_len = '0;
      bus.i_num_rows = '0; bus.i_pause = '0; bus.i_transpose = 1'b0;
      bus4.en = 1'b1; bus4.i_start = 1'b0; bus4.i_base = '0; bus4.i_row_len = '0;
      bus4.i_num_rows = '0; bus4.i_pause = '0; bus4.i_transpose = 1'b0;
      tick();
      tick();
      check("reset", {15'd0, flags(), bus.o_addr}, 32'd0);
      rst = 1'b0;
      tick();

      // T1 row-major 3x2, with a stray i_start during RUN that must be ignored
      start(0, 3, 2, 0, 1'b0);
      exp_run("t1_a0", FRun, 0);
      bus.i_start = 1'b1; bus.i_base = 12'd100;
      exp_run("t1_a1", FRun, 1);
      bus.i_start = 1'b0;
      exp_run("t1_a2", FRe, 2);
      exp_run("t1_a3", FRun, 3);
      exp_run("t1_a4", FRun, 4);
      exp_run("t1_a5", FLast, 5);
      exp_fl("t1_done", FDone);
      exp_fl("t1_idle", FIdle);

      // T2 same walk with a 2-cycle bubble between rows
      start(0, 3, 2, 2, 1'b0);
      exp_run("t2_a0", FRun, 0);
      exp_run("t2_a1", FRun, 1);
      exp_run("t2_a2", FRe, 2);
      exp_run("t2_p0", FPau, 2);
      exp_run("t2_p1", FPau, 2);
      exp_run("t2_a3", FRun, 3);
      exp_run("t2_a4", FRun, 4);
      exp_run("t2_a5", FLast, 5);
      exp_fl("t2_done", FDone);

      // T3 transposed, base 16, C=3, R=2
      start(16, 3, 2, 0, 1'b1);
      exp_run("t3_a16", FRun, 16);
      exp_run("t3_a18", FRun, 18);
      exp_run("t3_a20", FRe, 20);
      exp_run("t3_a17", FRun, 17);
      exp_run("t3_a19", FRun, 19);
      exp_run("t3_a21", FLast, 21);
      exp_fl("t3_done", FDone);
      exp_fl("t3_idle", FIdle);

      // T4 en low every other cycle: each address held for two cycles
      start(0, 3, 2, 0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         logic [4:0] f;
         f = (k == 5) ? FLast : (k == 2) ? FRe : FRun;
         bus.en = 1'b0;
         exp_run($sformatf("t4_hold%0d", k), f, k);
         bus.en = 1'b1;
         exp_run($sformatf("t4_adv%0d", k), f, k);
      end
      bus.en = 1'b0;
      exp_fl("t4_done", FDone);
      exp_fl("t4_idle_en0", FIdle);
      bus.en = 1'b1;

      // T5 4-bit address wrap
      bus4.i_base = 4'd14; bus4.i_row_len = 8'd4; bus4.i_num_rows = 8'd1;
      bus4.i_start = 1'b1;
      tick();
      bus4.i_start = 1'b0;
      a5 = '{14, 15, 0, 1};
      f5 = '{FRun, FRun, FRun, FLast};
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t5_a%0d", k),
               {23'd0, bus4.o_valid, bus4.o_row_end, bus4.o_last, bus4.o_addr},
               {23'd0, f5[k][4:2], 4'(a5[k])});
         tick();
      end
      check("t5_done", {31'd0, bus4.o_done}, 32'd1);
      tick();

      // T6 empty configs go straight to DONE without a valid cycle
      start(5, 0, 4, 0, 1'b0);
      exp_fl("t6_c0_done", FDone);
      exp_fl("t6_c0_idle", FIdle);
      start(5, 4, 0, 0, 1'b0);
      exp_fl("t6_r0_done", FDone);

      // Reset mid-pass aborts with everything cleared and no DONE pulse
      start(0, 3, 2, 0, 1'b0);
      exp_run("rst_a0", FRun, 0);
      exp_run("rst_a1", FRun, 1);
      exp_run("rst_a2", FRe, 2);
      check("rst_a3", {15'd0, flags(), bus.o_addr}, {15'd0, FRun, 12'd3});
      rst = 1'b1;
      tick();
      check("rst_clear", {15'd0, flags(), bus.o_addr}, 32'd0);
      rst = 1'b0;
      tick();
      exp_fl("rst_no_done", FIdle);

      // Back-to-back start is accepted on the IDLE cycle after DONE
      start(7, 1, 1, 0, 1'b0);
      exp_run("b2b_a7", FLast, 7);
      exp_fl("b2b_done", FDone);
      start(9, 1, 1, 0, 1'b0);
      exp_run("b2b_a9", FLast, 9);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
